// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: reads operands with writeback bypass, stalls on scoreboard hazards,
// and hands registered operands to execute over valid/ready.
module operand_fetch_stage #(
   parameter int DATA_W   = 64,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 31
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [ADDR_W-1:0] id_rn,
   input  logic [ADDR_W-1:0] id_rm,
   input  logic              id_use_rm,
   input  logic [DATA_W-1:0] id_imm,
   input  logic [ADDR_W-1:0] id_rd,
   input  logic              id_regwrite,
   output logic [ADDR_W-1:0] rf_rdAddrA,
   output logic [ADDR_W-1:0] rf_rdAddrB,
   input  logic [DATA_W-1:0] rf_rdDataA,
   input  logic [DATA_W-1:0] rf_rdDataB,
   input  logic              wb_write,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              ex_valid,
   input  logic              ex_ready,
   output logic [DATA_W-1:0] ex_opA,
   output logic [DATA_W-1:0] ex_opB,
   output logic [ADDR_W-1:0] ex_rd,
   output logic              ex_regwrite
);
   localparam int N = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] Z = ADDR_W'(ZERO_REG);
   logic [N-1:0]      r_busy;
   logic              r_valid, r_regwrite;
   logic [DATA_W-1:0] r_opA, r_opB;
   logic [ADDR_W-1:0] r_rd;
   logic              w_hit_a, w_hit_b, w_haz_a, w_haz_b, w_acc;
   logic [DATA_W-1:0] w_src_a, w_src_b;
   logic [N-1:0]      w_set, w_clr;
   assign rf_rdAddrA = id_rn;
   assign rf_rdAddrB = id_rm;
   assign w_hit_a = wb_write && wb_addr == id_rn;
   assign w_hit_b = wb_write && wb_addr == id_rm;
   assign w_haz_a = r_busy[id_rn] && !w_hit_a && id_rn != Z;
   assign w_haz_b = r_busy[id_rm] && !w_hit_b && id_rm != Z;
   // zero register is tested first so a writeback to it never bypasses
   assign w_src_a = (id_rn == Z) ? '0 : w_hit_a ? wb_data : rf_rdDataA;
   assign w_src_b = (id_rm == Z) ? '0 : w_hit_b ? wb_data : rf_rdDataB;
   assign id_ready = !(w_haz_a || (id_use_rm && w_haz_b)) && (!r_valid || ex_ready);
   assign w_acc = id_valid && id_ready;
   assign w_set = (w_acc && id_regwrite && id_rd != Z) ? N'(1) << id_rd : '0;
   assign w_clr = wb_write ? N'(1) << wb_addr : '0;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy     <= '0;
         r_valid    <= 1'b0;
         r_opA      <= '0;
         r_opB      <= '0;
         r_rd       <= '0;
         r_regwrite <= 1'b0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
         if (w_acc) begin
            r_valid    <= 1'b1;
            r_opA      <= w_src_a;
            r_opB      <= id_use_rm ? w_src_b : id_imm;
            r_rd       <= id_rd;
            r_regwrite <= id_regwrite;
         end else if (ex_ready) begin
            r_valid <= 1'b0;
         end
      end
   end
   assign ex_valid    = r_valid;
   assign ex_opA      = r_opA;
   assign ex_opB      = r_opB;
   assign ex_rd       = r_rd;
   assign ex_regwrite = r_regwrite;
endmodule
